// File: rtl/latch_bank_writer.sv
// Sequences writes into a bank of transparent D-latches over a shared d bus with one c per word.
// Setup, pulse and hold lengths are counted in clocks; every output is registered.
module latch_bank_writer #(
    parameter int N_LATCH = 6,
    parameter int W       = 8,
    parameter int T_SU    = 1,
    parameter int T_PW    = 2,
    parameter int T_H     = 1,
    localparam int AW     = (N_LATCH > 1) ? $clog2(N_LATCH) : 1
) (
    input  logic               clock,
    input  logic               reset_,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [AW-1:0]      req_addr,
    input  logic [W-1:0]       req_data,
    output logic [W-1:0]       d,
    output logic [N_LATCH-1:0] c,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int TMAX0 = (T_SU > T_PW) ? T_SU : T_PW;
    localparam int TMAX  = (TMAX0 > T_H) ? TMAX0 : T_H;
    localparam int CW    = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [W-1:0]       dat_q, dat_d;
    logic [N_LATCH-1:0] c_q, c_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [N_LATCH-1:0] c_sel;
    logic               addr_oob;

    // Out-of-range addresses match no bit, so c stays low for them automatically.
    always_comb begin
        c_sel = '0;
        for (int i = 0; i < N_LATCH; i++) begin
            if (addr_q == AW'(i)) begin
                c_sel[i] = 1'b1;
            end
        end
    end

    assign addr_oob = ({1'b0, addr_q} >= (AW+1)'(N_LATCH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = SETUP;
                    cnt_d   = CW'(T_SU - 1);
                    addr_d  = req_addr;
                    dat_d   = req_data;
                    c_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = CW'(T_PW - 1);
                    c_d     = c_sel;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CW'(T_H - 1);
                    c_d     = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    c_d     = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = addr_oob;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                c_d     = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dat_q   <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign d         = dat_q;
    assign c         = c_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
